tank_input_conditioner: RTL and testbench

//  Conditions merged player inputs (USB/DB9/DB15/keyboard OR-ed in clk_sys domain) before the ultra_tank core.

---
 rtl/tank_input_pkg.sv | 37 +++
 rtl/input_debounce.sv | 49 ++++
 rtl/tank_input_conditioner.sv | 209 ++++++++++++++++++++
 tb/tb_tank_input_conditioner.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_input_pkg.sv
// Shared types, input vector layout and stick-to-lever mapping for tank_input_conditioner.
package tank_input_pkg;

    // Layout of the merged raw input vector fed to the debouncer.
    localparam int unsigned NumInputs = 13;
    localparam int unsigned IdxJoy1   = 0;
    localparam int unsigned IdxJoy2   = 4;
    localparam int unsigned IdxFire   = 8;
    localparam int unsigned IdxStart  = 10;
    localparam int unsigned IdxCoin   = 12;

    // Lever bit positions: player 1 owns {W_Fw,W_Bk,X_Fw,X_Bk}, player 2 owns {Y_Fw,Y_Bk,Z_Fw,Z_Bk}.
    localparam int unsigned LeverLsbP1 = 4;
    localparam int unsigned LeverLsbP2 = 0;

    typedef logic [3:0] dir_t;         // {up,down,left,right}
    typedef logic [3:0] lever_code_t;  // {Fw_a,Bk_a,Fw_b,Bk_b}, active high

    typedef enum logic [1:0] {CoinIdle, CoinPulse, CoinGap} coin_state_t;

    function automatic lever_code_t map_dir(input dir_t dir);
        lever_code_t code;
        case (dir)
            4'b1010: code = 4'b0010;  // UL
            4'b1000: code = 4'b1010;  // U
            4'b1001: code = 4'b1000;  // UR
            4'b0001: code = 4'b1001;  // R
            4'b0101: code = 4'b0100;  // DR
            4'b0100: code = 4'b0101;  // D
            4'b0110: code = 4'b0001;  // DL
            4'b0010: code = 4'b0110;  // L
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser plus tick-sampled history debouncer; a bit's level changes only
// after DEB_SAMPLES consecutive equal samples.
module input_debounce #(
    parameter int unsigned WIDTH       = 13,
    parameter int unsigned DEB_SAMPLES = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0]                  sync1_q, sync2_q;
    logic [WIDTH-1:0]                  level_q, level_d;
    logic [WIDTH-1:0][DEB_SAMPLES-1:0] hist_q, hist_d;

    always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_d[i] = {hist_q[i][DEB_SAMPLES-2:0], sync2_q[i]};
                if (&hist_d[i]) begin
                    level_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    level_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            level_q <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end

    assign dout = level_q;

endmodule

// File: rtl/tank_input_conditioner.sv
// Conditions merged player inputs for the ultra_tank core: debounce, stick-to-lever mapping with
// direction settling, and rate-limited fixed-width coin pulses.
module tank_input_conditioner #(
    parameter int unsigned TICK_DIV         = 12000,
    parameter int unsigned DEB_SAMPLES      = 4,
    parameter int unsigned SETTLE_TICKS     = 3,
    parameter int unsigned COIN_PULSE_TICKS = 50,
    parameter int unsigned COIN_GAP_TICKS   = 100
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [3:0] joy1_dir,
    input  logic [3:0] joy2_dir,
    input  logic [1:0] fire,
    input  logic [1:0] start,
    input  logic       coin,
    output logic [7:0] lever_n,
    output logic [1:0] fire_o,
    output logic [1:0] start_n,
    output logic [1:0] coin_n,
    output logic       coin_busy
);
    import tank_input_pkg::*;

    localparam int unsigned PrescW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SettleW = $clog2(SETTLE_TICKS + 1);
    localparam int unsigned CoinMax = (COIN_PULSE_TICKS > COIN_GAP_TICKS) ?
                                      COIN_PULSE_TICKS : COIN_GAP_TICKS;
    localparam int unsigned CoinW   = $clog2(CoinMax + 1);

    localparam logic [PrescW-1:0]  PrescLast  = PrescW'(TICK_DIV - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_TICKS - 1);
    localparam logic [CoinW-1:0]   PulseLast  = CoinW'(COIN_PULSE_TICKS - 1);
    localparam logic [CoinW-1:0]   GapLast    = CoinW'(COIN_GAP_TICKS - 1);

    logic [PrescW-1:0]    presc_q;
    logic                 tick;
    logic [NumInputs-1:0] raw_in, deb;
    lever_code_t          lever_code [2];
    logic [7:0]           lever_n_d, lever_n_q;
    logic [1:0]           fire_q, start_n_q;

    // Prescaler
    always_ff @(posedge clk_sys) begin
        if (reset || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick   = (presc_q == PrescLast);
    assign raw_in = {coin, start, fire, joy2_dir, joy1_dir};

    input_debounce #(
        .WIDTH       (NumInputs),
        .DEB_SAMPLES (DEB_SAMPLES)
    ) u_debounce (
        .clk_sys (clk_sys),
        .reset   (reset),
        .tick    (tick),
        .din     (raw_in),
        .dout    (deb)
    );

    // Per-player settle filter: a new code must hold for SETTLE_TICKS ticks, neutral commits fast.
    for (genvar p = 0; p < 2; p++) begin : g_settle
        dir_t             dir;
        lever_code_t      mapped;
        lever_code_t      cand_q, cand_d, commit_q, commit_d;
        logic [SettleW-1:0] cnt_q, cnt_d;

        assign dir    = (p == 0) ? deb[IdxJoy1 +: 4] : deb[IdxJoy2 +: 4];
        assign mapped = map_dir(dir);

        always_comb begin
            cand_d   = cand_q;
            commit_d = commit_q;
            cnt_d    = cnt_q;
            if (mapped != cand_q) begin
                cand_d = mapped;
                cnt_d  = '0;
            end else if (tick && (cand_q != commit_q)) begin
                if ((cand_q == '0) || (cnt_q == SettleLast)) begin
                    commit_d = cand_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                cand_q   <= '0;
                commit_q <= '0;
                cnt_q    <= '0;
            end else begin
                cand_q   <= cand_d;
                commit_q <= commit_d;
                cnt_q    <= cnt_d;
            end
        end

        assign lever_code[p] = commit_q;
    end

    always_comb begin
        lever_n_d = '1;
        lever_n_d[LeverLsbP1 +: 4] = ~lever_code[0];
        lever_n_d[LeverLsbP2 +: 4] = ~lever_code[1];
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lever_n_q <= 8'hFF;
            fire_q    <= 2'b00;
            start_n_q <= 2'b11;
        end else begin
            lever_n_q <= lever_n_d;
            fire_q    <= deb[IdxFire +: 2];
            start_n_q <= ~deb[IdxStart +: 2];
        end
    end

    // Coin FSM
    coin_state_t      coin_state_q, coin_state_d;
    logic [CoinW-1:0] coin_cnt_q, coin_cnt_d;
    logic [1:0]       pending_q, pending_d;
    logic             coin_prev_q, coin_edge, pend_dec;
    logic [1:0]       coin_n_q;
    logic             coin_busy_q;

    assign coin_edge = deb[IdxCoin] & ~coin_prev_q;

    always_comb begin
        coin_state_d = coin_state_q;
        coin_cnt_d   = coin_cnt_q;
        pend_dec     = 1'b0;
        unique case (coin_state_q)
            CoinIdle: begin
                if (pending_q != 2'd0) begin
                    coin_state_d = CoinPulse;
                    coin_cnt_d   = '0;
                    pend_dec     = 1'b1;
                end
            end
            CoinPulse: begin
                if (tick) begin
                    if (coin_cnt_q == PulseLast) begin
                        coin_state_d = CoinGap;
                        coin_cnt_d   = '0;
                    end else begin
                        coin_cnt_d = coin_cnt_q + 1'b1;
                    end
                end
            end
            CoinGap: begin
                if (tick) begin
                    if (coin_cnt_q == GapLast) begin
                        coin_state_d = CoinIdle;
                        coin_cnt_d   = '0;
                    end else begin
                        coin_cnt_d = coin_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                coin_state_d = CoinIdle;
                coin_cnt_d   = '0;
            end
        endcase

        // Simultaneous edge and decrement cancel; otherwise saturate at 3.
        pending_d = pending_q;
        if (coin_edge && !pend_dec) begin
            if (pending_q != 2'd3) begin
                pending_d = pending_q + 2'd1;
            end
        end else if (!coin_edge && pend_dec) begin
            pending_d = pending_q - 2'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_state_q <= CoinIdle;
            coin_cnt_q   <= '0;
            pending_q    <= 2'd0;
            coin_prev_q  <= 1'b0;
            coin_n_q     <= 2'b11;
            coin_busy_q  <= 1'b0;
        end else begin
            coin_state_q <= coin_state_d;
            coin_cnt_q   <= coin_cnt_d;
            pending_q    <= pending_d;
            coin_prev_q  <= deb[IdxCoin];
            coin_n_q     <= (coin_state_d == CoinPulse) ? 2'b00 : 2'b11;
            coin_busy_q  <= (coin_state_d != CoinIdle) || (pending_d != 2'd0);
        end
    end

    assign lever_n   = lever_n_q;
    assign fire_o    = fire_q;
    assign start_n   = start_n_q;
    assign coin_n    = coin_n_q;
    assign coin_busy = coin_busy_q;

endmodule

// File: tb/tb_tank_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output changes with timing windows; a monitor
// compares every observed output change against the queue head.
module tb_tank_input_conditioner;

    localparam int unsigned T      = 4;    // TICK_DIV
    localparam int unsigned DEB    = 4;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned PULSE  = 50;
    localparam int unsigned GAP    = 100;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [3:0] joy1_dir, joy2_dir;
    logic [1:0] fire, start;
    logic       coin;
    logic [7:0] lever_n;
    logic [1:0] fire_o, start_n, coin_n;
    logic       coin_busy;

    tank_input_conditioner #(
        .TICK_DIV         (T),
        .DEB_SAMPLES      (DEB),
        .SETTLE_TICKS     (SETTLE),
        .COIN_PULSE_TICKS (PULSE),
        .COIN_GAP_TICKS   (GAP)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .joy1_dir  (joy1_dir),
        .joy2_dir  (joy2_dir),
        .fire      (fire),
        .start     (start),
        .coin      (coin),
        .lever_n   (lever_n),
        .fire_o    (fire_o),
        .start_n   (start_n),
        .coin_n    (coin_n),
        .coin_busy (coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [14:0] val;
        int          ref_cyc;  // -1: measure from the previous observed change
        int          lo;
        int          hi;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    logic [14:0] prev_out;
    int          last_change = 0;
    logic [14:0] obs;

    assign obs = {lever_n, fire_o, start_n, coin_n, coin_busy};

    function automatic logic [14:0] ov(input logic [7:0] lv, input logic [1:0] fo,
                                       input logic [1:0] sn, input logic [1:0] cn,
                                       input logic cb);
        return {lv, fo, sn, cn, cb};
    endfunction

    localparam logic [14:0] IdleOut = {8'hFF, 2'b00, 2'b11, 2'b11, 1'b0};

    always @(negedge clk_sys) begin : monitor
        exp_t e;
        int   base;
        int   d;
        if (mon_en && (obs !== prev_out)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_change: cycle %0d got %h, required %h (no change)",
                         cyc, obs, prev_out);
            end else begin
                e = exp_q.pop_front();
                base = (e.ref_cyc < 0) ? last_change : e.ref_cyc;
                d = cyc - base;
                n_checks++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h, required %h (cycle %0d)", e.name, obs, e.val, cyc);
                end
                n_checks++;
                if (d < e.lo || d > e.hi) begin
                    n_fail++;
                    $display("FAIL %s_timing: delay %0d cycles, required %0d..%0d",
                             e.name, d, e.lo, e.hi);
                end
            end
            prev_out    = obs;
            last_change = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input string name, input logic [14:0] val, input int ref_cyc,
                        input int lo, input int hi);
        exp_t e;
        e.name = name;
        e.val = val;
        e.ref_cyc = ref_cyc;
        e.lo = lo;
        e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        exp_t e;
        int   n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk_sys);
            n++;
        end
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: timed out, got %h, required %h", e.name, obs, e.val);
        end
    endtask

    task automatic check_now(input string name, input logic [14:0] val);
        n_checks++;
        if (obs !== val) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, obs, val);
        end
    endtask

    // Settled lever latency: 2 sync cycles + DEB + SETTLE ticks (+-1 tick) + output register.
    localparam int LevLo = 2 + (DEB + SETTLE - 1) * T;
    localparam int LevHi = 2 + (DEB + SETTLE + 1) * T + 2;
    localparam int DebLo = 2 + (DEB - 1) * T;
    localparam int DebHi = 2 + (DEB + 1) * T + 2;
    localparam int RelLo = 12;
    localparam int RelHi = 2 + (DEB + 2) * T;

    logic [3:0] dir_tab [8] = '{4'b1000, 4'b1001, 4'b0001, 4'b0101,
                                4'b0100, 4'b0110, 4'b0010, 4'b1010};
    logic [7:0] lev_tab [8] = '{8'h5F, 8'h7F, 8'h6F, 8'hBF, 8'hAF, 8'hEF, 8'h9F, 8'hDF};

    initial begin
        int s;
        reset = 1'b1;
        joy1_dir = '0;
        joy2_dir = '0;
        fire = '0;
        start = '0;
        coin = 1'b0;
        step(3);
        check_now("reset_state", IdleOut);
        prev_out    = obs;
        last_change = cyc;
        mon_en      = 1'b1;
        reset       = 1'b0;

        // 1: activity then reset mid-stream
        s = cyc;
        joy1_dir = 4'b1000;
        start = 2'b01;
        fire = 2'b10;
        push("t1_fire_start", ov(8'hFF, 2'b10, 2'b10, 2'b11, 1'b0), s, DebLo, DebHi);
        push("t1_lever_up", ov(8'h5F, 2'b10, 2'b10, 2'b11, 1'b0), s, LevLo, LevHi);
        drain(200);
        step(8);
        s = cyc;
        reset = 1'b1;
        joy1_dir = '0;
        start = '0;
        fire = '0;
        push("t1_reset_mid", IdleOut, s, 1, 1);
        step(3);
        reset = 1'b0;
        drain(10);
        step(10 * T);
        check_now("t1_after_reset", IdleOut);

        // 2: all eight player-1 directions, then release
        for (int i = 0; i < 8; i++) begin
            s = cyc;
            joy1_dir = dir_tab[i];
            push($sformatf("t2_dir%0d", i), ov(lev_tab[i], 2'b00, 2'b11, 2'b11, 1'b0),
                 s, LevLo, LevHi);
            drain(100);
            step(4 * T);
        end
        s = cyc;
        joy1_dir = '0;
        push("t2_release", IdleOut, s, RelLo, RelHi);
        drain(100);
        step(4 * T);

        // 3: short fire pulse filtered, long hold passes
        fire = 2'b01;
        step(2 * T);
        fire = 2'b00;
        step(6 * T);
        check_now("t3_pulse_filtered", IdleOut);
        s = cyc;
        fire = 2'b01;
        push("t3_hold_rise", ov(8'hFF, 2'b01, 2'b11, 2'b11, 1'b0), s, DebLo, DebHi);
        step(6 * T);
        s = cyc;
        fire = 2'b00;
        push("t3_hold_fall", IdleOut, s, DebLo, DebHi);
        drain(100);
        step(4 * T);

        // 4: player 2 U -> (1-tick L) -> UR; any L code (lever_n[3:0]=1001) pops as a bad value
        s = cyc;
        joy2_dir = 4'b1000;
        push("t4_up", ov(8'hF5, 2'b00, 2'b11, 2'b11, 1'b0), s, LevLo, LevHi);
        drain(100);
        step(4 * T);
        joy2_dir = 4'b0010;
        step(T);
        s = cyc;
        joy2_dir = 4'b1001;
        push("t4_upright", ov(8'hF7, 2'b00, 2'b11, 2'b11, 1'b0), s, LevLo, LevHi);
        drain(100);
        step(4 * T);
        check_now("t4_upright_steady", ov(8'hF7, 2'b00, 2'b11, 2'b11, 1'b0));
        s = cyc;
        joy2_dir = '0;
        push("t4_release", IdleOut, s, RelLo, RelHi);
        drain(100);
        step(4 * T);

        // 5: opposing directions are neutral
        joy1_dir = 4'b1100;
        step(12 * T);
        check_now("t5_up_down", IdleOut);
        joy1_dir = 4'b0011;
        step(12 * T);
        check_now("t5_left_right", IdleOut);
        joy1_dir = 4'b0000;
        step(8 * T);
        check_now("t5_neutral", IdleOut);

        // 6: five coin presses -> four pulses (pending saturates at 3)
        s = cyc;
        push("t6_busy", ov(8'hFF, 2'b00, 2'b11, 2'b11, 1'b1), s, DebLo, DebHi);
        for (int i = 0; i < 4; i++) begin
            push($sformatf("t6_pulse%0d_start", i), ov(8'hFF, 2'b00, 2'b11, 2'b00, 1'b1), -1,
                 (i == 0) ? 1 : 4 * GAP - 2, (i == 0) ? 1 : 4 * GAP + 1);
            push($sformatf("t6_pulse%0d_end", i), ov(8'hFF, 2'b00, 2'b11, 2'b11, 1'b1), -1,
                 4 * PULSE - 3, 4 * PULSE);
        end
        push("t6_idle", IdleOut, -1, 4 * GAP - 3, 4 * GAP);
        for (int i = 0; i < 5; i++) begin
            coin = 1'b1;
            step(5 * T);
            coin = 1'b0;
            step(5 * T);
        end
        drain(4 * (PULSE + GAP) * T + 500);
        step(4 * T);

        s = cyc;
        coin = 1'b1;
        push("t6b_busy", ov(8'hFF, 2'b00, 2'b11, 2'b11, 1'b1), s, DebLo, DebHi);
        push("t6b_pulse_start", ov(8'hFF, 2'b00, 2'b11, 2'b00, 1'b1), -1, 1, 1);
        step(5 * T);
        coin = 1'b0;
        step(15 * T);
        drain(50);
        s = cyc;
        reset = 1'b1;
        push("t6b_reset_mid_pulse", IdleOut, s, 1, 1);
        step(3);
        reset = 1'b0;
        drain(10);
        step((PULSE + 10) * T);
        check_now("t6b_no_further_pulse", IdleOut);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
